spi_master_clkgen_mode: RTL and testbench
=========================================

Name: spi_master_clkgen_mode

Overview:
- Parametrised SPI serial-clock generator for the SPI master datapath; successor to the fixed 8-bit divider clock generator.
- Adds:
  - configurable divider width;
  - CPOL/CPHA modes with sample/shift strobes;
  - glitch-free divider reload;
  - a clean stop that always finishes at idle level (DRAIN state);
  - a leading-edge counter.
- Feeds the TX shift register (spi_shift) and the RX sampler (spi_sample).

Parameters:
- DIV_W, 8: width of clk_div; half-period = clk_div+1 clk cycles.
- CNT_W, 6: width of edge_cnt.
- RST_DIV, 0: divider value loaded at reset.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  request clock run; level-sensitive.
- cpol  in  1  idle level of spi_clk; sampled on IDLE->RUN.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; sampled on IDLE->RUN.
- clk_div  in  DIV_W  half-period minus one.
- clk_div_valid  in  1  load strobe for clk_div.
- spi_clk  out  1  serial clock (registered).
- spi_rise  out  1  pulse: spi_clk rises on next clk edge.
- spi_fall  out  1  pulse: spi_clk falls on next clk edge.
- spi_sample  out  1  pulse: data-capture edge next cycle.
- spi_shift  out  1  pulse: data-launch edge next cycle.
- busy  out  1  state != IDLE.
- edge_cnt  out  CNT_W  leading edges since last IDLE->RUN; wraps modulo 2^CNT_W.

Behaviour:
- Reset: state=IDLE, counter=0, div_act=div_pend=RST_DIV, sclk_int=0, cpol_q=cpha_q=0, edge_cnt=0, all strobes 0, busy=0, spi_clk=0.
- spi_clk = sclk_int XOR cpol_q, registered.
  - Leading edge: sclk_int 0->1. Trailing edge: sclk_int 1->0.
  - rise/fall are derived from the actual spi_clk direction.
- Strobes:
  - Combinational, asserted only in the cycle where counter==div_act in RUN or DRAIN. The toggle appears on the following clk edge.
  - spi_sample = leading if cpha_q==0, else trailing. spi_shift = the other edge.
  - Exactly one of rise/fall and exactly one of sample/shift per toggle.
- Divider:
  - clk_div_valid writes div_pend in any state.
  - div_act <= div_pend in IDLE, or in the cycle counter wraps (counter==div_act).
  - A new value therefore never truncates a half-period in progress.
  - clk_div_valid in the wrap cycle: the new value is used for the next half-period.
- Counter: counts 0..div_act, then resets to 0 and toggles sclk_int. div_act=0 gives spi_clk at clk/2.
- State machine:
  - IDLE: counter=0, sclk_int=0. If en=1, go to RUN; cpol_q/cpha_q<=cpol/cpha; edge_cnt<=0. The first toggle occurs div_act+1 cycles after entering RUN.
  - RUN: counts and toggles. edge_cnt increments on each leading-edge toggle. If en=0 and sclk_int=0 and counter==0, go to IDLE. If en=0 and sclk_int=1, go to DRAIN.
  - DRAIN: keeps counting, ignores en, emits the trailing-edge strobes, toggles to sclk_int=0, then goes to IDLE.
  - en deasserted mid-low-phase (sclk_int=0, counter!=0): abort to IDLE next cycle, no strobe. Only a partial low phase is lost.
- Simultaneous: en drop in the same cycle as a leading toggle completes the toggle (sclk_int becomes 1), then enters DRAIN.
- cpol/cpha changes while busy have no effect until the next IDLE->RUN.
- Reset mid-operation: immediate return to reset values. spi_clk goes to 0 regardless of cpol; cpol_q reapplies on the next run.

Optional Feature:
- Macro SPI_CLKGEN_STRETCH_EN.
- Defined: adds input port hold (1 bit). While hold=1 in RUN/DRAIN, counter and sclk_int freeze and no strobes are emitted. It allows a slow peripheral or FIFO-empty condition to stretch the current phase. hold is ignored in IDLE.
- Undefined: no hold port; behaviour as above.

Decomposition:
- Package spi_master_pkg holds:
  - typedef enum logic [1:0] {CG_IDLE, CG_RUN, CG_DRAIN} clkgen_state_e;
  - spi_mode_t struct {cpol, cpha};
  - localparam SPI_DIV_W_DEFAULT=8.
- No sub-module needed. Optional: a spi_master_clkgen_div counter sub-module (counter + div_act/div_pend reload) if reused by the CS-timing block.

Test Plan:
- Reset, clk_div=3 valid, cpol=0,cpha=0, en=1 for 40 cycles -> first spi_rise 4 cycles after busy; period 8 clk; sample pulses coincide with rise; edge_cnt=5 after 5 rises.
- cpol=1,cpha=1, clk_div=0 -> spi_clk idles 1, toggles every clk; spi_sample coincides with spi_rise (trailing edge); shift with fall.
- clk_div=5 running, write clk_div=1 mid-half-period -> current half-period still 6 cycles; following half-periods 2 cycles; no short pulse.
- en dropped while sclk_int=1, clk_div=2 -> DRAIN; trailing strobe emitted; spi_clk returns to cpol level; busy falls the cycle after the toggle. en reasserted during DRAIN is ignored.
- en dropped during low phase with counter=1 -> IDLE next cycle, no strobe; re-enable restarts with edge_cnt=0.
- rstn asserted while spi_clk=1 mid-run -> spi_clk, strobes, busy, edge_cnt all 0 asynchronously. With SPI_CLKGEN_STRETCH_EN: hold=1 for 7 cycles in RUN -> spi_clk period extended by exactly 7 cycles.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master blocks: clock-generator states, mode pair, default divider width.
package spi_master_pkg;

  typedef enum logic [1:0] {CG_IDLE, CG_RUN, CG_DRAIN} clkgen_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam int SPI_DIV_W_DEFAULT = 8;

endpackage

// File: rtl/spi_master_clkgen_mode.sv
// SPI serial-clock generator with CPOL/CPHA strobes, glitch-free divider reload and a drain-to-idle stop.
// Optional phase stretching via input hold when SPI_CLKGEN_STRETCH_EN is defined.
module spi_master_clkgen_mode
  import spi_master_pkg::*;
#(
  parameter int          DIV_W   = SPI_DIV_W_DEFAULT,
  parameter int          CNT_W   = 6,
  parameter int unsigned RST_DIV = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             clk_div_valid,
`ifdef SPI_CLKGEN_STRETCH_EN
  input  logic             hold,
`endif
  output logic             spi_clk,
  output logic             spi_rise,
  output logic             spi_fall,
  output logic             spi_sample,
  output logic             spi_shift,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt
);

  clkgen_state_e    state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             sclk_q, sclk_d;
  logic             spi_clk_q, spi_clk_d;
  spi_mode_t        mode_q, mode_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  logic frz, active, tick, leading, trailing;

`ifdef SPI_CLKGEN_STRETCH_EN
  assign frz = hold;
`else
  assign frz = 1'b0;
`endif

  always_comb begin
    active     = (state_q != CG_IDLE) && !frz;
    tick       = active && (cnt_q == div_act_q);
    leading    = tick && !sclk_q;
    trailing   = tick && sclk_q;
    div_pend_d = clk_div_valid ? clk_div : div_pend_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    sclk_d     = sclk_q;
    mode_d     = mode_q;
    edge_cnt_d = edge_cnt_q;
    case (state_q)
      CG_IDLE: begin
        cnt_d     = '0;
        sclk_d    = 1'b0;
        div_act_d = div_pend_d;
        if (en) begin
          state_d    = CG_RUN;
          mode_d     = '{cpol: cpol, cpha: cpha};
          edge_cnt_d = '0;
        end
      end
      CG_RUN, CG_DRAIN: begin
        if (tick) begin
          // Reload only at the wrap so a half-period in progress is never cut short.
          cnt_d     = '0;
          sclk_d    = ~sclk_q;
          div_act_d = div_pend_d;
          if (leading) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
            if (!en && state_q == CG_RUN) state_d = CG_DRAIN;
          end else if (state_q == CG_DRAIN || !en) begin
            state_d = CG_IDLE;
          end
        end else if (active) begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == CG_RUN && !en) begin
            if (sclk_q) begin
              state_d = CG_DRAIN;
            end else begin
              state_d = CG_IDLE;
              cnt_d   = '0;
            end
          end
        end
      end
      default: state_d = CG_IDLE;
    endcase
    spi_clk_d = sclk_d ^ mode_d.cpol;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= CG_IDLE;
      cnt_q      <= '0;
      div_act_q  <= DIV_W'(RST_DIV);
      div_pend_q <= DIV_W'(RST_DIV);
      sclk_q     <= 1'b0;
      spi_clk_q  <= 1'b0;
      mode_q     <= '0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      sclk_q     <= sclk_d;
      spi_clk_q  <= spi_clk_d;
      mode_q     <= mode_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign spi_clk    = spi_clk_q;
  assign spi_rise   = tick && !spi_clk_q;
  assign spi_fall   = tick && spi_clk_q;
  assign spi_sample = mode_q.cpha ? trailing : leading;
  assign spi_shift  = mode_q.cpha ? leading : trailing;
  assign busy       = (state_q != CG_IDLE);
  assign edge_cnt   = edge_cnt_q;

endmodule

// File: tb/tb_spi_master_clkgen_mode.sv
// Scoreboard bench for spi_master_clkgen_mode: a half-period countdown model predicts each cycle's outputs.
module tb_spi_master_clkgen_mode;

  localparam int DIV_W = 8;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             en = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [DIV_W-1:0] clk_div = '0;
  logic             clk_div_valid = 1'b0;
  logic             hold = 1'b0;
  logic             spi_clk, spi_rise, spi_fall, spi_sample, spi_shift, busy;
  logic [CNT_W-1:0] edge_cnt;

  int vectors = 0;
  int errors  = 0;

  spi_master_clkgen_mode #(.DIV_W(DIV_W), .CNT_W(CNT_W), .RST_DIV(0)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .clk_div_valid(clk_div_valid),
`ifdef SPI_CLKGEN_STRETCH_EN
    .hold(hold),
`endif
    .spi_clk(spi_clk), .spi_rise(spi_rise), .spi_fall(spi_fall),
    .spi_sample(spi_sample), .spi_shift(spi_shift), .busy(busy), .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  // Model: level of the internal clock, cycles remaining in the current half-period, drain flag.
  typedef struct {
    bit busy, lvl, cpol, cpha;
    int rem, ecnt;
  } snap_t;

  snap_t sb[$];
  bit m_busy, m_lvl, m_cpol, m_cpha, m_drain;
  int m_rem, m_ecnt, m_pend;

  always @(posedge clk) begin
    automatic int pend_n;
    if (!rstn) begin
      m_busy = 0; m_lvl = 0; m_cpol = 0; m_cpha = 0; m_drain = 0;
      m_rem = 1; m_ecnt = 0; m_pend = 0;
    end else begin
      pend_n = clk_div_valid ? int'(clk_div) : m_pend;
      if (!m_busy) begin
        if (en) begin
          m_busy = 1; m_drain = 0; m_cpol = cpol; m_cpha = cpha;
          m_ecnt = 0; m_lvl = 0; m_rem = pend_n + 1;
        end
      end else if (!hold) begin
        if (m_rem == 1) begin
          if (!m_lvl) begin
            m_lvl = 1; m_ecnt = (m_ecnt + 1) % (1 << CNT_W);
            if (!en) m_drain = 1;
          end else begin
            m_lvl = 0;
            if (m_drain || !en) m_busy = 0;
          end
          m_rem = pend_n + 1;
        end else if (!m_drain && !en && !m_lvl) begin
          m_busy = 0;
        end else begin
          if (!m_drain && !en) m_drain = 1;
          m_rem--;
        end
      end
      m_pend = pend_n;
    end
    sb.push_back('{busy: m_busy, lvl: m_lvl, cpol: m_cpol, cpha: m_cpha, rem: m_rem, ecnt: m_ecnt});
  end

  always @(negedge clk) begin
    snap_t s;
    bit tk, ck;
    logic [5+CNT_W:0] exp_v, act_v;
    if (sb.size() == 0) begin
      vectors++; errors++;
      $display("FAIL scoreboard_empty @%0t: got no expected entry, want one per cycle", $time);
    end else begin
      s  = sb.pop_front();
      tk = s.busy && (s.rem == 1) && !hold;
      ck = s.lvl ^ s.cpol;
      exp_v = {ck, tk && !ck, tk && ck, tk && (s.cpha ? s.lvl : !s.lvl),
               tk && (s.cpha ? !s.lvl : s.lvl), s.busy, CNT_W'(s.ecnt)};
      act_v = {spi_clk, spi_rise, spi_fall, spi_sample, spi_shift, busy, edge_cnt};
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs @%0t: got %b want %b (spi_clk,rise,fall,sample,shift,busy,edge_cnt)",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_div(input int d);
    clk_div = DIV_W'(d); clk_div_valid = 1'b1;
    step(1);
    clk_div_valid = 1'b0;
  endtask

  // Asserts reset away from the clock edge and checks the outputs clear before any clock arrives.
  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({spi_clk, spi_rise, spi_fall, spi_sample, spi_shift, busy, edge_cnt} !== '0) begin
      errors++;
      $display("FAIL %s: got clk=%b r=%b f=%b smp=%b sh=%b busy=%b ecnt=%0d, want all 0",
               tag, spi_clk, spi_rise, spi_fall, spi_sample, spi_shift, busy, edge_cnt);
    end
    en = 1'b0;
    step(2);
    @(negedge clk); #1;
    rstn = 1'b1;
    step(1);
  endtask

  initial begin
    #1 rstn = 1'b0;
    step(3);
    @(negedge clk); #1 rstn = 1'b1;
    step(1);

    // Mode 0, half-period 4.
    load_div(3); step(2);
    cpol = 0; cpha = 0; en = 1; step(40);
    en = 0; step(12);

    // Mode 3 at clk/2.
    load_div(0); step(1);
    cpol = 1; cpha = 1; en = 1; step(20);
    cpol = 0; cpha = 0; step(6);
    en = 0; step(6);

    // Divider change mid-half-period.
    load_div(5); step(1);
    en = 1; step(3);
    load_div(1); step(16);
    en = 0; step(10);

    // Drop en in the high phase, re-raise during drain.
    load_div(2); step(1);
    cpol = 0; en = 1; step(5);
    en = 0; step(1);
    en = 1; step(1);
    en = 0; step(8);

    // Drop en one cycle into the low phase, then restart.
    load_div(3); step(1);
    en = 1; step(2);
    en = 0; step(3);
    en = 1; step(12);
    en = 0; step(10);

    // Asynchronous reset while spi_clk is high.
    en = 1; step(6);
    do_reset("reset_mid_run");

`ifdef SPI_CLKGEN_STRETCH_EN
    load_div(3); step(1);
    en = 1; step(6);
    hold = 1; step(7);
    hold = 0; step(20);
    en = 0; step(10);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      cpol = 1'($urandom);
      cpha = 1'($urandom);
      clk_div_valid = ($urandom_range(0, 9) == 0);
      clk_div = DIV_W'($urandom_range(0, 6));
`ifdef SPI_CLKGEN_STRETCH_EN
      hold = ($urandom_range(0, 7) == 0);
`endif
      step(1);
    end
    clk_div_valid = 0; hold = 0; en = 0;
    step(20);
    do_reset("reset_final");
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
